// File: rtl/mem_arbiter.sv
// Multi-port arbiter in front of a single-ported synchronous memory.
// Each transaction takes IDLE -> ACCESS -> RESP. Grants are round-robin or fixed priority.
module mem_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 6144,
    parameter int RR_MODE   = 1
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [NUM_PORTS-1:0]              req_valid,
    input  logic [NUM_PORTS*ADDR_W-1:0]       req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]       req_wdata,
    input  logic [NUM_PORTS*(DATA_W/8)-1:0]   req_wstrb,
    output logic [NUM_PORTS-1:0]              req_ready,
    output logic [NUM_PORTS-1:0]              req_err,
    output logic [DATA_W-1:0]                 req_rdata,
    output logic                              mem_en,
    output logic [DATA_W/8-1:0]               mem_we,
    output logic [$clog2(MEM_WORDS)-1:0]      mem_addr,
    output logic [DATA_W-1:0]                 mem_wdata,
    input  logic [DATA_W-1:0]                 mem_rdata,
    output logic                              busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int MA_W   = $clog2(MEM_WORDS);
    localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) * 64'(STRB_W);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [IDX_W-1:0]    last_r;
    logic [IDX_W-1:0]    gnt_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [STRB_W-1:0]   wstrb_r;
    logic [IDX_W-1:0]    win_s;
    logic                found_s;
    logic                in_range_s;
    logic                is_read_s;

    assign in_range_s = (64'(addr_r) < MEM_BYTES);
    assign is_read_s  = (wstrb_r == {STRB_W{1'b0}});
    assign busy       = (state_r != ST_IDLE);

    // Winner selection: round-robin search starts just after the last grant.
    always_comb begin
        win_s   = {IDX_W{1'b0}};
        found_s = 1'b0;
        if (RR_MODE != 0) begin
            for (int k = 1; k <= NUM_PORTS; k++) begin
                win_s   = (!found_s && req_valid[(int'(last_r) + k) % NUM_PORTS])
                          ? IDX_W'((int'(last_r) + k) % NUM_PORTS) : win_s;
                found_s = found_s | req_valid[(int'(last_r) + k) % NUM_PORTS];
            end
        end else begin
            for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                win_s = req_valid[k] ? IDX_W'(k) : win_s;
            end
            found_s = |req_valid;
        end
    end

    // Next-state logic for the three-phase transaction sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:   state_s = found_s ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_s = ST_RESP;
            ST_RESP:   state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Capture the winning request; later valid changes cannot disturb it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_r  <= IDX_W'(NUM_PORTS - 1);
            gnt_r   <= {IDX_W{1'b0}};
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            wstrb_r <= {STRB_W{1'b0}};
        end else if (state_r == ST_IDLE && found_s) begin
            last_r  <= win_s;
            gnt_r   <= win_s;
            addr_r  <= req_addr[int'(win_s) * ADDR_W +: ADDR_W];
            wdata_r <= req_wdata[int'(win_s) * DATA_W +: DATA_W];
            wstrb_r <= req_wstrb[int'(win_s) * STRB_W +: STRB_W];
        end
    end

    // Output decode from the state and latched request only.
    always_comb begin
        req_ready = {NUM_PORTS{1'b0}};
        req_err   = {NUM_PORTS{1'b0}};
        req_rdata = {DATA_W{1'b0}};
        mem_en    = 1'b0;
        mem_we    = {STRB_W{1'b0}};
        mem_addr  = {MA_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        case (state_r)
            ST_ACCESS: begin
                mem_en    = in_range_s;
                mem_we    = in_range_s ? wstrb_r : {STRB_W{1'b0}};
                mem_addr  = MA_W'(addr_r >> OFF_W);
                mem_wdata = wdata_r;
            end
            ST_RESP: begin
                req_ready[gnt_r] = 1'b1;
                req_err[gnt_r]   = ~in_range_s;
                req_rdata        = (in_range_s && is_read_s) ? mem_rdata : {DATA_W{1'b0}};
            end
            default: begin
                req_ready = {NUM_PORTS{1'b0}};
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: a 3-port round-robin instance and a 2-port fixed-priority instance
// share one behavioural memory image; monitors compare every response against queued expectations.
module tb_mem_arbiter;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct {
        logic [12:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } macc_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [2:0]  a_valid, a_ready, a_err;
    logic [95:0] a_addr, a_wdata;
    logic [11:0] a_wstrb;
    logic [31:0] a_rdata, a_mem_wdata, a_mem_rdata;
    logic        a_mem_en, a_busy;
    logic [3:0]  a_mem_we;
    logic [12:0] a_mem_addr;

    logic [1:0]  b_valid, b_ready, b_err;
    logic [63:0] b_addr, b_wdata;
    logic [7:0]  b_wstrb;
    logic [31:0] b_rdata, b_mem_wdata, b_mem_rdata;
    logic        b_mem_en, b_busy;
    logic [3:0]  b_mem_we;
    logic [12:0] b_mem_addr;

    logic [31:0] mem [0:6143];
    rsp_t  a_q[$];
    rsp_t  b_q[$];
    macc_t m_q[$];

    mem_arbiter #(.NUM_PORTS(3), .DATA_W(32), .ADDR_W(32), .MEM_WORDS(6144), .RR_MODE(1)) u_rr (
        .clk(clk), .resetn(resetn),
        .req_valid(a_valid), .req_addr(a_addr), .req_wdata(a_wdata), .req_wstrb(a_wstrb),
        .req_ready(a_ready), .req_err(a_err), .req_rdata(a_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    mem_arbiter #(.NUM_PORTS(2), .DATA_W(32), .ADDR_W(32), .MEM_WORDS(6144), .RR_MODE(0)) u_fp (
        .clk(clk), .resetn(resetn),
        .req_valid(b_valid), .req_addr(b_addr), .req_wdata(b_wdata), .req_wstrb(b_wstrb),
        .req_ready(b_ready), .req_err(b_err), .req_rdata(b_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // Memory model: read data registered one cycle after mem_en.
    always @(posedge clk) begin
        if (a_mem_en) begin
            mem[a_mem_addr] <= merge(mem[a_mem_addr], a_mem_wdata, a_mem_we);
            a_mem_rdata     <= mem[a_mem_addr];
        end
        if (b_mem_en) b_mem_rdata <= mem[b_mem_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_a(input int p, input logic [31:0] d, input logic e);
        rsp_t r;
        r.port = p; r.rdata = d; r.err = e;
        a_q.push_back(r);
    endtask

    task automatic push_b(input int p, input logic [31:0] d);
        rsp_t r;
        r.port = p; r.rdata = d; r.err = 1'b0;
        b_q.push_back(r);
    endtask

    task automatic push_m(input logic [12:0] ad, input logic [3:0] we, input logic [31:0] wd);
        macc_t m;
        m.addr = ad; m.we = we; m.wdata = wd;
        m_q.push_back(m);
    endtask

    task automatic set_a(input int p, input logic [31:0] ad, input logic [31:0] wd,
                         input logic [3:0] st);
        a_addr[p*32 +: 32]  = ad;
        a_wdata[p*32 +: 32] = wd;
        a_wstrb[p*4 +: 4]   = st;
    endtask

    // Monitor for the round-robin instance: response side and memory side.
    always @(negedge clk) begin
        rsp_t        e;
        macc_t       m;
        logic [2:0]  oh;
        if (resetn) begin
            if (|a_ready) begin
                if (a_q.size() == 0) begin
                    chk("a_unexpected_ready", 64'(a_ready), 64'd0);
                end else begin
                    e  = a_q.pop_front();
                    oh = 3'b001 << e.port;
                    chk("a_ready_port", 64'(a_ready), 64'(oh));
                    chk("a_err", 64'(a_err), e.err ? 64'(oh) : 64'd0);
                    chk("a_rdata", 64'(a_rdata), 64'(e.rdata));
                end
            end else begin
                chk("a_quiet_outside_resp", {29'd0, a_err, a_rdata}, 64'd0);
            end
            if (a_mem_en) begin
                if (m_q.size() == 0) begin
                    chk("a_unexpected_mem_en", 64'(a_mem_addr), 64'h1_0000);
                end else begin
                    m = m_q.pop_front();
                    chk("a_mem_addr", 64'(a_mem_addr), 64'(m.addr));
                    chk("a_mem_we", 64'(a_mem_we), 64'(m.we));
                    chk("a_mem_wdata", 64'(a_mem_wdata), 64'(m.wdata));
                end
            end else begin
                chk("a_we_without_en", 64'(a_mem_we), 64'd0);
            end
        end
    end

    // Monitor for the fixed-priority instance.
    always @(negedge clk) begin
        rsp_t       e;
        logic [1:0] oh;
        if (resetn && |b_ready) begin
            if (b_q.size() == 0) begin
                chk("b_unexpected_ready", 64'(b_ready), 64'd0);
            end else begin
                e  = b_q.pop_front();
                oh = 2'b01 << e.port;
                chk("b_ready_port", 64'(b_ready), 64'(oh));
                chk("b_err", 64'(b_err), 64'd0);
                chk("b_rdata", 64'(b_rdata), 64'(e.rdata));
            end
        end
    end

    // Hold each port valid until it has seen the requested number of ready pulses.
    task automatic run_a(input int r0, input int r1, input int r2, input bit chk_lat);
        int rem[3];
        int last_it[3];
        int it;
        bit done;
        rem[0] = r0; rem[1] = r1; rem[2] = r2;
        it = 0;
        while (a_busy && it < 20) begin @(negedge clk); it++; end
        it = 0;
        for (int p = 0; p < 3; p++) begin
            last_it[p] = -1;
            a_valid[p] = (rem[p] > 0);
        end
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            it++;
            for (int p = 0; p < 3; p++) begin
                if (rem[p] > 0 && a_ready[p]) begin
                    // IDLE, ACCESS and RESP cycles inclusive
                    if (chk_lat && last_it[p] < 0) chk("latency_cycles", 64'(it + 1), 64'd3);
                    if (last_it[p] >= 0) chk("rr_period", 64'(it - last_it[p]), 64'd9);
                    last_it[p] = it;
                    rem[p]--;
                    if (rem[p] == 0) a_valid[p] = 1'b0;
                end
            end
            done = (rem[0] == 0) && (rem[1] == 0) && (rem[2] == 0);
            if (!done && it > 100) begin
                chk("a_timeout", 64'd1, 64'd0);
                a_valid = 3'b000;
                done = 1'b1;
            end
        end
    endtask

    task automatic run_b(input int r0, input int r1);
        int rem[2];
        int it;
        rem[0] = r0; rem[1] = r1;
        it = 0;
        b_valid = {(r1 > 0), (r0 > 0)};
        while ((rem[0] > 0 || rem[1] > 0) && it <= 100) begin
            @(negedge clk);
            it++;
            for (int p = 0; p < 2; p++) begin
                if (rem[p] > 0 && b_ready[p]) begin
                    rem[p]--;
                    if (rem[p] == 0) b_valid[p] = 1'b0;
                end
            end
        end
        if (rem[0] > 0 || rem[1] > 0) begin
            chk("b_timeout", 64'd1, 64'd0);
            b_valid = 2'b00;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[1]    <= 32'h0000_0101;
        mem[2]    <= 32'h0000_0202;
        mem[3]    <= 32'h0000_0303;
        mem[4]    <= 32'hDEAD_BEEF;
        mem[8]    <= 32'h1122_3344;
        mem[6143] <= 32'hCAFE_F00D;
        resetn  = 1'b0;
        a_valid = 3'b000; a_addr = 96'd0; a_wdata = 96'd0; a_wstrb = 12'd0;
        b_valid = 2'b00;  b_addr = 64'd0; b_wdata = 64'd0; b_wstrb = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_ready", 64'(a_ready), 64'd0);
        chk("rst_mem_en", 64'(a_mem_en), 64'd0);
        chk("rst_rdata", 64'(a_rdata), 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // single read
        set_a(0, 32'h0000_0010, 32'd0, 4'b0000);
        push_a(0, 32'hDEAD_BEEF, 1'b0); push_m(13'd4, 4'b0000, 32'd0);
        run_a(1, 0, 0, 1'b1);
        // byte write then read-back with sub-word address bits set
        set_a(1, 32'h0000_0020, 32'h0000_AB00, 4'b0010);
        push_a(1, 32'd0, 1'b0); push_m(13'd8, 4'b0010, 32'h0000_AB00);
        run_a(0, 1, 0, 1'b1);
        set_a(2, 32'h0000_0023, 32'd0, 4'b0000);
        push_a(2, 32'h1122_AB44, 1'b0); push_m(13'd8, 4'b0000, 32'd0);
        run_a(0, 0, 1, 1'b1);
        // out of range read and write: no memory access at all
        set_a(0, 32'h0000_6000, 32'd0, 4'b0000);
        push_a(0, 32'd0, 1'b1);
        run_a(1, 0, 0, 1'b1);
        set_a(1, 32'hFFFF_FFFC, 32'h1234_5678, 4'b1111);
        push_a(1, 32'd0, 1'b1);
        run_a(0, 1, 0, 1'b1);
        // last byte of memory is in range; port 2 becomes last grant
        set_a(2, 32'h0000_5FFF, 32'd0, 4'b0000);
        push_a(2, 32'hCAFE_F00D, 1'b0); push_m(13'd6143, 4'b0000, 32'd0);
        run_a(0, 0, 1, 1'b1);

        // round-robin with all three held valid for two rounds
        set_a(0, 32'h0000_0004, 32'd0, 4'b0000);
        set_a(1, 32'h0000_0008, 32'd0, 4'b0000);
        set_a(2, 32'h0000_000C, 32'd0, 4'b0000);
        for (int r = 0; r < 2; r++) begin
            push_a(0, 32'h0000_0101, 1'b0); push_m(13'd1, 4'b0000, 32'd0);
            push_a(1, 32'h0000_0202, 1'b0); push_m(13'd2, 4'b0000, 32'd0);
            push_a(2, 32'h0000_0303, 1'b0); push_m(13'd3, 4'b0000, 32'd0);
        end
        run_a(2, 2, 2, 1'b0);

        // reset during ACCESS abandons the transaction
        @(negedge clk);
        a_valid = 3'b011;
        @(posedge clk);
        #2;
        chk("pre_rst_mem_en", 64'(a_mem_en), 64'd1);
        resetn = 1'b0;
        #1;
        chk("rst_mid_mem_en", 64'(a_mem_en), 64'd0);
        chk("rst_mid_busy", 64'(a_busy), 64'd0);
        chk("rst_mid_ready", 64'(a_ready), 64'd0);
        @(negedge clk);
        push_a(0, 32'h0000_0101, 1'b0); push_m(13'd1, 4'b0000, 32'd0);
        push_a(1, 32'h0000_0202, 1'b0); push_m(13'd2, 4'b0000, 32'd0);
        resetn = 1'b1;
        run_a(1, 1, 0, 1'b0);

        // fixed priority: port 0 wins until it drops valid
        b_addr  = {32'h0000_0008, 32'h0000_0004};
        push_b(0, 32'h0000_0101); push_b(0, 32'h0000_0101); push_b(0, 32'h0000_0101);
        push_b(1, 32'h0000_0202);
        run_b(3, 1);

        repeat (5) @(negedge clk);
        chk("a_rsp_queue_drained", 64'(a_q.size()), 64'd0);
        chk("a_mem_queue_drained", 64'(m_q.size()), 64'd0);
        chk("b_rsp_queue_drained", 64'(b_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of requesters (1..8).
REQ-002 SHALL have parameter DATA_W, default 32: data width (32 or 64).
REQ-003 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-004 SHALL have parameter MEM_WORDS, default 6144: memory depth in DATA_W words.
REQ-005 SHALL have parameter RR_MODE, default 1: 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
REQ-006 SHALL use one clock and an asynchronous, active-low reset:
  clk  in  1  single clock; all state on posedge
  resetn  in  1  asynchronous active-low reset
REQ-007 SHALL provide the following ports:
  req_valid  in  NUM_PORTS  per-port request
  req_addr  in  NUM_PORTS*ADDR_W  byte address; port i at [i*ADDR_W +: ADDR_W]
  req_wdata  in  NUM_PORTS*DATA_W  write data
  req_wstrb  in  NUM_PORTS*DATA_W/8  byte strobes; all zero = read
  req_ready  out  NUM_PORTS  one-cycle completion pulse
  req_err  out  NUM_PORTS  one-cycle out-of-range pulse, coincident with ready
  req_rdata  out  DATA_W  read data, shared; valid while any ready is high
  mem_en  out  1  memory access strobe
  mem_we  out  DATA_W/8  byte write enables
  mem_addr  out  $clog2(MEM_WORDS)  word address
  mem_wdata  out  DATA_W  write data
  mem_rdata  in  DATA_W  read data, valid one cycle after mem_en
  busy  out  1  high in every state except IDLE

Function
REQ-008 SHALL implement a three-state FSM: IDLE -> ACCESS -> RESP -> IDLE.
REQ-009 In IDLE with any req_valid high, SHALL select a winner, latch its addr/wdata/wstrb and index, and go to ACCESS; with no valid, SHALL stay in IDLE.
REQ-010 With RR_MODE=1, SHALL search from (last_grant+1) mod NUM_PORTS upward with wrap-around; last_grant SHALL update on each grant.
REQ-011 With RR_MODE=0, SHALL grant the lowest-indexed valid port.
REQ-012 In ACCESS, SHALL drive mem_en=1, mem_addr=latched addr >> log2(DATA_W/8), mem_we=latched wstrb, mem_wdata=latched wdata, for exactly one cycle.
REQ-013 In range means latched addr < MEM_WORDS*DATA_W/8; out of range SHALL keep mem_en=0 and mem_we=0 in ACCESS.
REQ-014 In RESP, SHALL pulse req_ready[winner] for one cycle with req_rdata=mem_rdata for in-range reads, otherwise 0; req_err[winner] SHALL pulse with ready if out of range.
REQ-015 Latency SHALL be exactly 3 cycles from valid sampled in IDLE to ready; peak throughput SHALL be one transaction per 3 cycles.
REQ-016 Requesters SHALL hold valid stable until ready; a valid drop after grant SHALL NOT abort the transaction: the write commits and ready still pulses.
REQ-017 The winner's valid still high in the IDLE cycle after its RESP SHALL be treated as a new request.
REQ-018 Outside RESP, req_ready, req_err and req_rdata SHALL be 0; outside ACCESS, mem_en and mem_we SHALL be 0.
REQ-019 Addresses SHALL be treated as unsigned; bits below log2(DATA_W/8) SHALL be ignored.

Reset
REQ-020 On resetn low, SHALL asynchronously enter IDLE with all outputs 0 and last_grant=NUM_PORTS-1, so port 0 is granted first.
REQ-021 Reset asserted in ACCESS or RESP SHALL abandon the transaction with no ready pulse; a write already strobed in ACCESS may have committed.
REQ-022 After resetn is released, the first grant SHALL occur no earlier than the first posedge with resetn high.

Verification
REQ-023 Single read: port 0 reads addr 0x10, mem word 4 = 0xDEADBEEF -> mem_en at T+1 with mem_addr=4; req_ready[0] and req_rdata=0xDEADBEEF at T+2 relative to grant.
REQ-024 Byte write: port 1 writes wstrb=4'b0010, wdata=0x0000AB00, addr 0x20 -> one ACCESS cycle with mem_we=4'b0010, mem_addr=8; then req_ready[1], no req_err.
REQ-025 Round-robin fairness: NUM_PORTS=3, all valid held continuously -> grant order 0,1,2,0,1,2; each port completes once every 9 cycles.
REQ-026 Fixed priority: RR_MODE=0, ports 0 and 1 both held valid -> port 0 granted every transaction; port 1 granted only after port 0 drops valid.
REQ-027 Out of range: read at addr MEM_WORDS*4 -> mem_en stays 0; req_ready and req_err pulse together with req_rdata=0.
REQ-028 Reset mid-op: resetn low during ACCESS -> outputs 0 immediately with no ready pulse; after release, with ports 0 and 1 valid, port 0 is granted first.
